fifo_th: RTL
============

FIFO_TH -- requirements
Module: fifo_th

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of entries (>=2; need not be a power of two).
REQ-002 SHALL have parameter FIFO_WIDTH, default 8, data bits per entry.
REQ-003 SHALL have parameter AF_TH, default FIFO_DEPTH-2, almost-full threshold in entries.
REQ-004 SHALL have parameter AE_TH, default 2, almost-empty threshold in entries.
REQ-005 SHALL have parameter CNT_W, default $clog2(FIFO_DEPTH+1), occupancy counter width.
REQ-006 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  reset, synchronous, active-low
  flush  in  1  synchronous discard of all contents
  write_en  in  1  write request
  data_in  in  FIFO_WIDTH  write data
  full  out  1  count==FIFO_DEPTH
  almost_full  out  1  count>=AF_TH
  read_en  in  1  read request (pop)
  data_out  out  FIFO_WIDTH  head entry, first-word-fall-through
  empty  out  1  count==0
  almost_empty  out  1  count<=AE_TH
  cnt  out  CNT_W  current occupancy, 0..FIFO_DEPTH inclusive
  overflow  out  1  sticky, FIFO_TH_ERR_EN only
  underflow  out  1  sticky, FIFO_TH_ERR_EN only
  err_clr  in  1  clears sticky flags, FIFO_TH_ERR_EN only

Function
REQ-007 Write accepted (wr_acc) SHALL be write_en && (!full || rd_acc); accepted data stored at wptr on the clock edge.
REQ-008 Read accepted (rd_acc) SHALL be read_en && !empty; rptr advances on the edge.
REQ-009 Rejected requests SHALL leave pointers, count and memory unchanged.
REQ-010 Count SHALL update as count + wr_acc - rd_acc; full with simultaneous write and read leaves count at FIFO_DEPTH.
REQ-011 Write on empty with simultaneous read: write accepted, read rejected (no bypass); count becomes 1.
REQ-012 wptr/rptr SHALL wrap from FIFO_DEPTH-1 to 0 independently of power-of-two depth.
REQ-013 data_out SHALL be combinational mem[rptr]: zero-latency view of the head entry; a written entry appears on data_out the cycle after its write when the FIFO was empty; value unspecified while empty.
REQ-014 full, empty, almost_full, almost_empty, cnt SHALL be combinational decodes of the registered count.
REQ-015 flush SHALL zero count, wptr and rptr on the next edge, overriding write_en/read_en in that cycle; memory contents not cleared.
REQ-016 Memory array SHALL have no reset.

Reset
REQ-017 With rst_n low at an edge: count, wptr, rptr = 0; overflow, underflow = 0; hence empty=1, almost_empty=1, full=0, almost_full=0 (AF_TH>0), cnt=0.
REQ-018 Reset mid-operation SHALL discard all contents; rst_n overrides flush, err_clr and all requests.

Configuration
REQ-019 Macro FIFO_TH_ERR_EN defined: ports overflow, underflow, err_clr exist; overflow set on write_en && full && !read_en && !flush; underflow set on read_en && empty && !flush; both hold until err_clr; set in the same cycle as err_clr wins.
REQ-020 FIFO_TH_ERR_EN undefined: those three ports and their registers absent; rejection behaviour of REQ-009 unchanged.

Verification
REQ-021 Reset, then 16 writes 0x00..0x0F (DEPTH=16) -> full=1 and cnt=16 after 16th edge; almost_full=1 from cnt=14; data_out=0x00.
REQ-022 Full, write 0xAA with read_en same cycle -> cnt stays 16, 0x00 popped, 0xAA stored at old wptr; subsequent 16 reads return 0x01..0x0F, 0xAA.
REQ-023 DEPTH=5, 12 write/read pairs with data 1..12 -> pointers wrap twice, read order exactly 1..12, cnt never exceeds 1.
REQ-024 cnt=7, assert flush with write_en=1, read_en=1 -> next cycle cnt=0, empty=1, almost_empty=1; written word not retained.
REQ-025 FIFO_TH_ERR_EN: read_en on empty -> underflow=1 next cycle, cnt stays 0; err_clr pulse -> underflow=0; err_clr with write on full (no read) same cycle -> overflow=1.
REQ-026 Empty FIFO, write_en and read_en both high, data 0x5C -> cnt=1, empty=0, data_out=0x5C next cycle.

Source files
------------

// File: rtl/fifo_th.sv
// rtl/fifo_th.sv - synchronous first-word-fall-through FIFO with almost-full/almost-empty thresholds
// Optional sticky overflow/underflow flags with err_clr: define FIFO_TH_ERR_EN.
module fifo_th #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 8,
  parameter int AF_TH      = FIFO_DEPTH - 2,
  parameter int AE_TH      = 2,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  read_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      cnt
`ifdef FIFO_TH_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [PTR_W-1:0]      wptr_nxt;
  logic [PTR_W-1:0]      rptr_nxt;

  // Status flags decode only the registered count, never the requests.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign cnt          = count;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside a read; an empty FIFO never bypasses write data to the reader.
  assign rd_acc = read_en && !empty;
  assign wr_acc = write_en && (!full || rd_acc);

  // Explicit wrap so non-power-of-two depths work.
  assign wptr_nxt = (wptr == LAST_C) ? '0 : wptr + PTR_W'(1);
  assign rptr_nxt = (rptr == LAST_C) ? '0 : rptr + PTR_W'(1);

  assign data_out = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (wr_acc) wptr <= wptr_nxt;
      if (rd_acc) rptr <= rptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; reset and flush only suppress the write.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc) mem[wptr] <= data_in;
  end

`ifdef FIFO_TH_ERR_EN
  logic ov_set;
  logic un_set;

  assign ov_set = write_en && full && !read_en && !flush;
  assign un_set = read_en && empty && !flush;

  // A new error in the clearing cycle must not be lost, so set beats clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ov_set || (overflow && !err_clr);
      underflow <= un_set || (underflow && !err_clr);
    end
  end
`endif

endmodule
